// File: rtl/rob_commit_unit_if.sv
// ROB-head / register-file / data-memory bundle seen by the commit unit.
// Latency: none, wires only.
// Backpressure: stores stall on dm_ack; the ROB is advanced only by rob_pop.
interface rob_commit_unit_if #(
  parameter int ENTRY_W = 114,
  parameter int CNT_W   = 16
);
  // ROB head side
  logic               rob_empty;
  logic               rob_head_valid;
  logic [ENTRY_W-1:0] rob_head_entry;
  logic               rob_pop;
  // register-file write-back
  logic               rf_we;
  logic [4:0]         rf_wa;
  logic [31:0]        rf_wd;
  // data-memory store port
  logic               dm_req;
  logic [31:0]        dm_addr;
  logic [31:0]        dm_wd;
  logic               dm_ack;
  // front-end redirect and status
  logic               flush;
  logic [31:0]        redirect_pc;
  logic               store_err;
  logic [CNT_W-1:0]   retired_cnt;
  logic               busy;

  // The commit unit is the master: it consumes the head and drives retirement.
  modport master (
    input  rob_empty, rob_head_valid, rob_head_entry, dm_ack,
    output rob_pop, rf_we, rf_wa, rf_wd, dm_req, dm_addr, dm_wd,
           flush, redirect_pc, store_err, retired_cnt, busy
  );

  // ROB, register file, memory and front end together form the slave side.
  modport slave (
    output rob_empty, rob_head_valid, rob_head_entry, dm_ack,
    input  rob_pop, rf_we, rf_wa, rf_wd, dm_req, dm_addr, dm_wd,
           flush, redirect_pc, store_err, retired_cnt, busy
  );
endinterface

// File: rtl/rob_commit_unit.sv
// In-order retirement of the ROB head: RF write-back, store issue, mispredict flush.
// Latency: capture->COMMIT, pop one cycle later (non-store); retire period >= 4 clk_2.
// Backpressure: STORE waits for dm_ack up to STORE_TIMEOUT cycles, then gives up and flags store_err.
module rob_commit_unit #(
  parameter int ENTRY_W       = 114,
  parameter int STORE_TIMEOUT = 15,
  parameter int CNT_W         = 16
) (
  input logic               clk_2,
  input logic               rstn,
  rob_commit_unit_if.master bus
);

  // ROB entry layout, MSB first. pc_plus4 and the reserved control bits
  // travel with the entry but take no part in retirement.
  typedef struct packed {
    logic        valid;
    logic [4:0]  dest_reg;
    logic [31:0] ex_result;
    logic [31:0] mem_wd;
    logic [7:0]  ctrl_rsvd;
    logic        mispredict;
    logic        branch;
    logic        mem_write;
    logic        reg_write;
    logic [31:0] pc_plus4;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMMIT,
    ST_STORE,
    ST_POP,
    ST_SETTLE
  } state_t;

  localparam int TMO_W = $clog2(STORE_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(STORE_TIMEOUT - 1);

  logic [ENTRY_W-1:0] head_raw;
  entry_t             head;

  state_t             state_q, state_d;
  entry_t             hold_q, hold_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               store_tmo;

  // next values of the registered outputs
  logic               rob_pop_d, rf_we_d, dm_req_d, dm_launch_d, flush_d;
  logic               busy_d, store_err_d;
  logic [CNT_W-1:0]   cnt_d;

  // output registers
  logic               rob_pop_q, rf_we_q, dm_req_q, flush_q, busy_q, store_err_q;
  logic [4:0]         rf_wa_q;
  logic [31:0]        rf_wd_q, dm_addr_q, dm_wd_q, redirect_pc_q;
  logic [CNT_W-1:0]   cnt_q;

  assign head_raw = bus.rob_head_entry;
  assign head     = entry_t'(head_raw);

  // State, hold register and store timeout counter.
  always_ff @(posedge clk_2) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state: head is sampled only in IDLE; SETTLE gives the slow-clock
  // ROB time to move its head pointer before we look again.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    tmo_d     = tmo_q;
    store_tmo = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.rob_head_valid && !bus.rob_empty && head.valid) begin
          hold_d  = head;
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        tmo_d   = '0;
        state_d = hold_q.mem_write ? ST_STORE : ST_POP;
      end
      ST_STORE: begin
        // ack wins over a timeout landing in the same cycle
        if (bus.dm_ack) begin
          state_d = ST_POP;
        end else if (tmo_q == TMO_LAST) begin
          store_tmo = 1'b1;
          state_d   = ST_POP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_POP: begin
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop
  // and lines up with the state it belongs to.
  always_comb begin
    rf_we_d     = (state_d == ST_COMMIT) && hold_d.reg_write && (hold_d.dest_reg != 5'd0);
    dm_launch_d = (state_d == ST_COMMIT) && hold_d.mem_write;
    dm_req_d    = dm_launch_d || (state_d == ST_STORE);
    rob_pop_d   = (state_d == ST_POP);
    flush_d     = (state_d == ST_POP) && hold_d.branch && hold_d.mispredict;
    busy_d      = (state_d != ST_IDLE);
    store_err_d = store_err_q || store_tmo;
    cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, rob_pop_d};
  end

  // Registered outputs; data fields only load when their strobe is raised
  // so dm_addr/dm_wd stay put for the whole store.
  always_ff @(posedge clk_2) begin
    if (!rstn) begin
      rob_pop_q     <= 1'b0;
      rf_we_q       <= 1'b0;
      rf_wa_q       <= '0;
      rf_wd_q       <= '0;
      dm_req_q      <= 1'b0;
      dm_addr_q     <= '0;
      dm_wd_q       <= '0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      store_err_q   <= 1'b0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
    end else begin
      rob_pop_q   <= rob_pop_d;
      rf_we_q     <= rf_we_d;
      dm_req_q    <= dm_req_d;
      flush_q     <= flush_d;
      store_err_q <= store_err_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      if (rf_we_d) begin
        rf_wa_q <= hold_d.dest_reg;
        rf_wd_q <= hold_d.ex_result;
      end
      if (dm_launch_d) begin
        dm_addr_q <= hold_d.ex_result;
        dm_wd_q   <= hold_d.mem_wd;
      end
      if (flush_d) begin
        redirect_pc_q <= hold_d.ex_result;
      end
    end
  end

  assign bus.rob_pop     = rob_pop_q;
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_wa       = rf_wa_q;
  assign bus.rf_wd       = rf_wd_q;
  assign bus.dm_req      = dm_req_q;
  assign bus.dm_addr     = dm_addr_q;
  assign bus.dm_wd       = dm_wd_q;
  assign bus.flush       = flush_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.store_err   = store_err_q;
  assign bus.retired_cnt = cnt_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: directed retire scenarios then randomized entries vs a transaction model.
// Latency: model predicts per-cycle outputs from entry fields and the chosen dm_ack delay.
// Backpressure: dm_ack is withheld for a chosen number of STORE cycles, or never (timeout).
module tb_rob_commit_unit;
  localparam int ENTRY_W       = 114;
  localparam int CNT_W         = 16;
  localparam int STORE_TIMEOUT = 15;

  logic clk_2 = 1'b0;
  logic rstn  = 1'b0;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  // model state that persists across retirements
  int   exp_cnt = 0;
  logic exp_err = 1'b0;

  rob_commit_unit_if #(.ENTRY_W(ENTRY_W), .CNT_W(CNT_W)) bus ();

  rob_commit_unit #(
    .ENTRY_W(ENTRY_W), .STORE_TIMEOUT(STORE_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk_2(clk_2),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk_2 = ~clk_2;
  always @(posedge clk_2) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [113:0] mk(input logic [4:0] dest, input logic [31:0] ex,
                                      input logic [31:0] wd, input logic rw, input logic mw,
                                      input logic br, input logic mp, input logic [7:0] rsvd,
                                      input logic [31:0] pc);
    return {1'b1, dest, ex, wd, rsvd, mp, br, mw, rw, pc};
  endfunction

  function automatic logic [113:0] rnd_entry();
    return mk(5'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 8'($urandom), $urandom);
  endfunction

  task automatic present(input logic [113:0] e);
    bus.rob_head_entry = e;
    bus.rob_head_valid = 1'b1;
    bus.rob_empty      = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rob_pop"}, bus.rob_pop, 0);
    check({tag, " rf_we"}, bus.rf_we, 0);
    check({tag, " rf_wa"}, bus.rf_wa, 0);
    check({tag, " rf_wd"}, bus.rf_wd, 0);
    check({tag, " dm_req"}, bus.dm_req, 0);
    check({tag, " dm_addr"}, bus.dm_addr, 0);
    check({tag, " dm_wd"}, bus.dm_wd, 0);
    check({tag, " flush"}, bus.flush, 0);
    check({tag, " redirect_pc"}, bus.redirect_pc, 0);
    check({tag, " store_err"}, bus.store_err, 0);
    check({tag, " retired_cnt"}, bus.retired_cnt, 0);
    check({tag, " busy"}, bus.busy, 0);
  endtask

  // Waits (bounded) for the head to be captured; the head is presented in
  // IDLE, so busy must show on the very next sample.
  task automatic wait_capture(output bit ok);
    int w;
    w = 0;
    while (bus.busy !== 1'b1 && w < 8) begin
      @(negedge clk_2);
      w++;
    end
    check("capture_latency", w, 1);
    ok = (bus.busy === 1'b1);
  endtask

  // Retire one presented entry and check every output cycle by cycle.
  // gate: 0 keep head valid but swap in nxt; 1 drop valid; 2 raise rob_empty;
  //       3 keep valid with entry valid bit cleared.
  task automatic retire(input logic [113:0] e, input int ack_delay, input bit stray,
                        input int gate, input logic [113:0] nxt, output int commit_cyc);
    logic [4:0]  dest;
    logic [31:0] ex, wd;
    logic        rw, mw, br, mp, tmo, err_before, exp_we, exp_req;
    int          s, p, cnt_before;
    bit          ok;
    dest = e[112:108]; ex = e[107:76]; wd = e[75:44];
    rw = e[32]; mw = e[33]; br = e[34]; mp = e[35];
    tmo = mw && (ack_delay >= STORE_TIMEOUT);
    s = !mw ? 0 : (tmo ? STORE_TIMEOUT : ack_delay + 1);
    p = 1 + s;
    err_before = exp_err;
    cnt_before = exp_cnt;
    commit_cyc = -1;
    wait_capture(ok);
    if (!ok) return;
    commit_cyc = cyc;
    case (gate)
      0:       bus.rob_head_entry = nxt;
      1:       begin bus.rob_head_valid = 1'b0; bus.rob_head_entry = nxt; end
      2:       begin bus.rob_empty = 1'b1; bus.rob_head_entry = nxt; end
      default: bus.rob_head_entry = {1'b0, nxt[112:0]};
    endcase
    if (tmo) exp_err = 1'b1;
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    for (int c = 0; c <= p + 2; c++) begin
      exp_we  = (c == 0) && rw && (dest != 5'd0);
      exp_req = mw && (c <= s);
      check("rf_we", bus.rf_we, exp_we);
      if (exp_we) begin
        check("rf_wa", bus.rf_wa, dest);
        check("rf_wd", bus.rf_wd, ex);
      end
      check("dm_req", bus.dm_req, exp_req);
      if (exp_req) begin
        check("dm_addr", bus.dm_addr, ex);
        check("dm_wd", bus.dm_wd, wd);
      end
      check("rob_pop", bus.rob_pop, c == p);
      check("flush", bus.flush, (c == p) && br && mp);
      if (c == p && br && mp) check("redirect_pc", bus.redirect_pc, ex);
      check("busy", bus.busy, c <= p + 1);
      check("store_err", bus.store_err, (c >= p) ? exp_err : err_before);
      check("retired_cnt", bus.retired_cnt, (c >= p) ? exp_cnt : cnt_before);
      bus.dm_ack = (stray && c == 0) || (mw && !tmo && c == ack_delay + 1);
      if (c < p + 2) @(negedge clk_2);
    end
    bus.dm_ack = 1'b0;
  endtask

  initial begin
    logic [113:0] cur, nxt, ea, eb, ec;
    int  c1, c2, c3, cc, g, ad;
    bit  ok;

    // reset held with a valid head present
    bus.dm_ack    = 1'b0;
    present(mk(5'd7, 32'h1234, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h4));
    rstn = 1'b0;
    repeat (3) begin
      @(negedge clk_2);
      check_all_zero("reset");
    end
    bus.rob_head_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk_2);
    check("post_reset busy", bus.busy, 0);
    check("post_reset rob_pop", bus.rob_pop, 0);

    // ALU write-back
    cur = mk(5'd5, 32'h0000_00AA, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h100);
    present(cur);
    retire(cur, 0, 1'b0, 1, rnd_entry(), cc);
    check("alu retired_cnt", bus.retired_cnt, 1);

    // store, ack after three low cycles of dm_req
    cur = mk(5'd9, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h104);
    present(cur);
    retire(cur, 2, 1'b0, 1, rnd_entry(), cc);
    check("store_wait store_err", bus.store_err, 0);

    // store never acknowledged
    cur = mk(5'd0, 32'h0000_0200, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h108);
    present(cur);
    retire(cur, 100, 1'b0, 1, rnd_entry(), cc);
    check("timeout store_err", bus.store_err, 1);

    // mispredicted branch, then a correctly predicted one
    cur = mk(5'd0, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 32'h10C);
    present(cur);
    retire(cur, 0, 1'b0, 2, rnd_entry(), cc);
    cur = mk(5'd0, 32'h0000_0080, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h110);
    present(cur);
    retire(cur, 0, 1'b1, 3, rnd_entry(), cc);

    // RegWrite to r0, then RegWrite + MemWrite together
    cur = mk(5'd0, 32'hCAFE_0001, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h114);
    present(cur);
    retire(cur, 0, 1'b0, 1, rnd_entry(), cc);
    cur = mk(5'd17, 32'h0000_0300, 32'h5555_AAAA, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 32'h118);
    present(cur);
    retire(cur, 0, 1'b1, 1, rnd_entry(), cc);
    check("sticky store_err", bus.store_err, 1);

    // reset pulled in the middle of a store
    present(mk(5'd3, 32'h0000_0400, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h11C));
    wait_capture(ok);
    bus.rob_head_valid = 1'b0;
    repeat (2) @(negedge clk_2);
    check("rst_store dm_req_before", bus.dm_req, 1);
    rstn = 1'b0;
    @(negedge clk_2);
    check("rst_store dm_req", bus.dm_req, 0);
    check("rst_store rob_pop", bus.rob_pop, 0);
    check("rst_store busy", bus.busy, 0);
    check("rst_store retired_cnt", bus.retired_cnt, 0);
    check("rst_store store_err", bus.store_err, 0);
    rstn = 1'b1;
    exp_cnt = 0;
    exp_err = 1'b0;
    repeat (3) begin
      @(negedge clk_2);
      check("rst_store no_pop", bus.rob_pop, 0);
      check("rst_store idle", bus.busy, 0);
    end

    // three back-to-back heads
    ea = mk(5'd1, 32'h11, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h200);
    eb = mk(5'd2, 32'h22, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h204);
    ec = mk(5'd3, 32'h33, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h208);
    present(ea);
    retire(ea, 0, 1'b0, 0, eb, c1);
    retire(eb, 0, 1'b0, 0, ec, c2);
    retire(ec, 0, 1'b0, 1, rnd_entry(), c3);
    check("b2b spacing 1-2", c2 - c1, 4);
    check("b2b spacing 2-3", c3 - c2, 4);
    check("b2b retired_cnt", bus.retired_cnt, 3);

    // randomized entries, ack delays and head gating
    cur = rnd_entry();
    present(cur);
    for (int i = 0; i < 40; i++) begin
      nxt = rnd_entry();
      g   = $urandom_range(0, 3);
      ad  = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 20) : $urandom_range(0, 14);
      retire(cur, ad, 1'($urandom), g, nxt, cc);
      if (g != 0) begin
        repeat (2) begin
          @(negedge clk_2);
          check("gated head idle", bus.busy, 0);
        end
        present(nxt);
      end
      cur = nxt;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
